// File: rtl/srcnn_udiv_12ns_6ns_8_seq.sv
// rtl/srcnn_udiv_12ns_6ns_8_seq.sv - sequential unsigned restoring divider, one quotient bit per cycle
// Divides a din0_WIDTH dividend by a din1_WIDTH divisor; quotient saturates to dout_WIDTH.
module srcnn_udiv_12ns_6ns_8_seq #(
  parameter int ID         = 1,
  parameter int din0_WIDTH = 12,
  parameter int din1_WIDTH = 6,
  parameter int dout_WIDTH = 8
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [dout_WIDTH-1:0] dout,
  output logic [din1_WIDTH-1:0] rem,
  output logic                  ovf,
  output logic                  dz,
  output logic                  out_valid,
  input  logic                  out_ready
);

  localparam int CNT_W = $clog2(din0_WIDTH) + 0 * ID;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t                  state, state_next;
  logic [din0_WIDTH-1:0]   dividend;
  logic [din1_WIDTH-1:0]   divisor;
  logic [din1_WIDTH-1:0]   prem;
  logic [CNT_W-1:0]        cnt;

  logic [din1_WIDTH:0]     shifted;
  logic                    ge;
  logic [din1_WIDTH-1:0]   sub;
  logic [din1_WIDTH-1:0]   prem_next;
  logic [din0_WIDTH-1:0]   q_next;
  logic                    q_ovf;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  // The dividend register doubles as the quotient: bits leave at the top and quotient bits enter at the bottom.
  always_comb begin
    shifted   = {prem, dividend[din0_WIDTH-1]};
    ge        = (shifted >= {1'b0, divisor});
    sub       = shifted[din1_WIDTH-1:0] - divisor;
    prem_next = ge ? sub : shifted[din1_WIDTH-1:0];
    q_next    = {dividend[din0_WIDTH-2:0], ge};
    q_ovf     = |(q_next >> dout_WIDTH);
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid) state_next = CALC;
      CALC:    if (divisor == '0 || cnt == '0) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state    <= IDLE;
      dividend <= '0;
      divisor  <= '0;
      prem     <= '0;
      cnt      <= '0;
      dout     <= '0;
      rem      <= '0;
      ovf      <= 1'b0;
      dz       <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (in_valid) begin
            dividend <= din0;
            divisor  <= din1;
            prem     <= '0;
            cnt      <= CNT_W'(din0_WIDTH - 1);
          end
        end
        CALC: begin
          if (divisor == '0) begin
            dout <= '1;
            rem  <= '1;
            ovf  <= 1'b0;
            dz   <= 1'b1;
          end else begin
            dividend <= q_next;
            prem     <= prem_next;
            cnt      <= cnt - CNT_W'(1);
            if (cnt == '0) begin
              dout <= q_ovf ? '1 : q_next[dout_WIDTH-1:0];
              rem  <= prem_next;
              ovf  <= q_ovf;
              dz   <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_srcnn_udiv_12ns_6ns_8_seq.sv
// tb/tb_srcnn_udiv_12ns_6ns_8_seq.sv - self-checking bench for the sequential divider
// Directed cases, backpressure, mid-operation reset, random scoreboard and product round trip.
module tb_srcnn_udiv_12ns_6ns_8_seq;

  logic        ap_clk = 1'b0;
  logic        ap_rst = 1'b1;
  logic [11:0] din0 = '0;
  logic [5:0]  din1 = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  dout;
  logic [5:0]  rem;
  logic        ovf;
  logic        dz;
  logic        out_valid;
  logic        out_ready = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  always #5 ap_clk = ~ap_clk;

  srcnn_udiv_12ns_6ns_8_seq dut (
    .ap_clk   (ap_clk),
    .ap_rst   (ap_rst),
    .din0     (din0),
    .din1     (din1),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .dout     (dout),
    .rem      (rem),
    .ovf      (ovf),
    .dz       (dz),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: plain integer division with saturation and divide-by-zero convention.
  task automatic do_op(input int a, input int b, input int stall);
    int cyc, q, e_dout, e_rem, e_ovf, e_dz, e_lat;
    if (b == 0) begin
      e_dout = 255; e_rem = 63; e_ovf = 0; e_dz = 1; e_lat = 1;
    end else begin
      q      = a / b;
      e_ovf  = (q > 255) ? 1 : 0;
      e_dout = e_ovf ? 255 : q;
      e_rem  = a % b;
      e_dz   = 0;
      e_lat  = 12;
    end
    cyc = 0;
    while (!in_ready && cyc < 20) begin
      @(posedge ap_clk); #1; cyc++;
    end
    check("in_ready_before_accept", int'(in_ready), 1);
    din0 = 12'(a); din1 = 6'(b); in_valid = 1'b1;
    @(posedge ap_clk); #1;
    in_valid = 1'b0;
    cyc = 0;
    while (!out_valid && cyc < 40) begin
      in_valid = 1'($urandom); din0 = 12'($urandom); din1 = 6'($urandom);
      @(posedge ap_clk); #1; cyc++;
    end
    in_valid = 1'b0;
    check("latency", cyc, e_lat);
    check("dout", int'(dout), e_dout);
    check("rem", int'(rem), e_rem);
    check("ovf", int'(ovf), e_ovf);
    check("dz", int'(dz), e_dz);
    for (int i = 0; i < stall; i++) begin
      in_valid = 1'($urandom); din0 = 12'($urandom); din1 = 6'($urandom);
      @(posedge ap_clk); #1;
      check("stall_out_valid", int'(out_valid), 1);
      check("stall_in_ready", int'(in_ready), 0);
      check("stall_dout", int'(dout), e_dout);
      check("stall_rem", int'(rem), e_rem);
      check("stall_ovf_dz", int'({ovf, dz}), (e_ovf << 1) | e_dz);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge ap_clk); #1;
    out_ready = 1'b0;
    check("out_valid_drop", int'(out_valid), 0);
    check("in_ready_after", int'(in_ready), 1);
  endtask

  initial begin
    int a, b, ups;
    repeat (2) @(posedge ap_clk);
    #1 ap_rst = 1'b0;
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_dout", int'(dout), 0);
    check("rst_rem", int'(rem), 0);
    check("rst_ovf_dz", int'({ovf, dz}), 0);

    do_op(1785, 7, 0);
    do_op(100, 7, 0);
    do_op(4095, 63, 0);
    do_op(4095, 1, 0);
    do_op(256, 1, 0);
    do_op(255, 1, 0);
    do_op(37, 0, 0);
    do_op(0, 5, 0);
    do_op(1000, 9, 5);

    // Reset during iteration 6 must abort the operation silently.
    din0 = 12'd1785; din1 = 6'd7; in_valid = 1'b1;
    @(posedge ap_clk); #1;
    in_valid = 1'b0;
    repeat (6) @(posedge ap_clk);
    #1 ap_rst = 1'b1;
    @(posedge ap_clk); #1;
    ap_rst = 1'b0;
    check("midrst_in_ready", int'(in_ready), 1);
    check("midrst_out_valid", int'(out_valid), 0);
    check("midrst_dout", int'(dout), 0);
    check("midrst_rem", int'(rem), 0);
    check("midrst_ovf_dz", int'({ovf, dz}), 0);
    ups = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge ap_clk); #1;
      if (out_valid) ups++;
    end
    check("midrst_no_out_valid", ups, 0);
    do_op(100, 7, 0);

    for (int n = 0; n < 2000; n++) begin
      a = int'($urandom_range(0, 4095));
      case ($urandom_range(0, 3))
        0:       b = int'($urandom_range(0, 3));
        default: b = int'($urandom_range(0, 63));
      endcase
      do_op(a, b, int'($urandom_range(0, 3)));
    end

    for (int x = 0; x < 256; x++) begin
      b = int'($urandom_range(1, 63));
      if (x * b > 4095) b = 4095 / x;
      do_op(x * b, b, 0);
      check("rt_dout", int'(dout), x);
      check("rt_rem", int'(rem), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
